// File: rtl/fifo_sched_pkg.sv
// Shared defaults and read-side state encoding for the FIFO port scheduler.
package fifo_sched_pkg;

    localparam int DW_DEF    = 8;
    localparam int N_REQ_DEF = 4;

    // Output-buffer occupancy values
    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_TWO   = 2'd2;

    typedef enum logic [2:0] {
        RD_EMPTY,
        RD_FETCH,
        RD_ONE,
        RD_ONE_F,
        RD_TWO,
        RD_ILLEGAL
    } rd_state_e;

    // Names the implicit read state carried by (occupancy, read pending).
    function automatic rd_state_e rd_state(input logic [1:0] occ, input logic pend);
        case ({occ, pend})
            {OCC_EMPTY, 1'b0}: return RD_EMPTY;
            {OCC_EMPTY, 1'b1}: return RD_FETCH;
            {OCC_ONE,   1'b0}: return RD_ONE;
            {OCC_ONE,   1'b1}: return RD_ONE_F;
            {OCC_TWO,   1'b0}: return RD_TWO;
            default:           return RD_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin search: first asserted request at or after ptr_i, wrapping, wins.
module rr_arbiter
    import fifo_sched_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [PW-1:0]    ptr_i,
    input  logic             en_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [PW-1:0]    idx_o
);

    localparam logic [PW:0] NREQ_W = (PW+1)'(N_REQ);

    always_comb begin
        logic          found;
        logic [PW:0]   sum;
        logic [PW-1:0] cand;
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        sum   = '0;
        cand  = '0;
        for (int off = 0; off < N_REQ; off++) begin
            sum = {1'b0, ptr_i} + (PW+1)'(off);
            if (sum >= NREQ_W) begin
                sum = sum - NREQ_W;
            end
            cand = sum[PW-1:0];
            if (en_i && !found && req_i[cand]) begin
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_port_sched.sv
// Shares the FIFO write port among producers round-robin and turns the
// registered FIFO read port into a full-rate valid/ready stream.
module fifo_port_sched
    import fifo_sched_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int DW    = DW_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*DW-1:0] req_data,
    output logic [N_REQ-1:0]    gnt,
    output logic                fifo_wr_en,
    output logic [DW-1:0]       fifo_din,
    input  logic                fifo_full,
    output logic                fifo_rd_en,
    input  logic [DW-1:0]       fifo_dout,
    input  logic                fifo_empty,
    output logic                m_valid,
    output logic [DW-1:0]       m_data,
    input  logic                m_ready
);

    localparam int            PW       = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [PW-1:0] LAST_IDX = PW'(N_REQ - 1);

    logic             arb_en;
    logic [PW-1:0]    win_idx;
    logic [PW-1:0]    rr_ptr_q, rr_ptr_d;

    logic [1:0]       occ_q, occ_d;
    logic             rd_pend_q, rd_pend_d;
    logic [DW-1:0]    ob0_q, ob0_d;
    logic [DW-1:0]    ob1_q, ob1_d;
    logic             pop;
    logic [1:0]       occ_after_pop;
    logic [1:0]       fill;

    // Grants are gated by reset too, so nothing is written while rst is low.
    assign arb_en = rst & ~fifo_full;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_arb (
        .req_i (req),
        .ptr_i (rr_ptr_q),
        .en_i  (arb_en),
        .gnt_o (gnt),
        .idx_o (win_idx)
    );

    assign fifo_wr_en = |gnt;

    always_comb begin
        fifo_din = '0;
        if (fifo_wr_en) begin
            fifo_din = req_data[int'(win_idx)*DW +: DW];
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (fifo_wr_en) begin
            rr_ptr_d = (win_idx == LAST_IDX) ? '0 : win_idx + PW'(1);
        end
    end

    assign m_valid       = (occ_q != OCC_EMPTY);
    assign m_data        = ob0_q;
    assign pop           = m_valid & m_ready;
    assign occ_after_pop = occ_q - {1'b0, pop};
    // Slots committed after this edge: surviving words plus the one in flight.
    assign fill          = occ_after_pop + {1'b0, rd_pend_q};
    assign fifo_rd_en    = rst & ~fifo_empty & (fill < OCC_TWO);

    always_comb begin
        ob0_d     = ob0_q;
        ob1_d     = ob1_q;
        occ_d     = fill;
        rd_pend_d = fifo_rd_en;
        if (pop) begin
            ob0_d = ob1_q;
        end
        if (rd_pend_q) begin
            if (occ_after_pop == OCC_EMPTY) begin
                ob0_d = fifo_dout;
            end else begin
                ob1_d = fifo_dout;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_q  <= '0;
            occ_q     <= OCC_EMPTY;
            rd_pend_q <= 1'b0;
            ob0_q     <= '0;
            ob1_q     <= '0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            occ_q     <= occ_d;
            rd_pend_q <= rd_pend_d;
            ob0_q     <= ob0_d;
            ob1_q     <= ob1_d;
        end
    end

    a_no_two_with_pend: assert property (@(posedge clk) disable iff (!rst)
        rd_state(occ_q, rd_pend_q) != RD_ILLEGAL);

endmodule

// File: tb/tb_fifo_port_sched.sv
// Scoreboard bench: reference arbiter and 16x8 FIFO model drive expectations,
// an independent monitor checks every consumer transfer.
module tb_fifo_port_sched;

    localparam int N  = 4;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N*DW-1:0] req_data = '0;
    logic            m_ready = 1'b0;

    logic [N-1:0]    gnt;
    logic            fifo_wr_en, fifo_rd_en, fifo_full, fifo_empty, m_valid;
    logic [DW-1:0]   fifo_din, fifo_dout, m_data;

    fifo_port_sched #(.N_REQ(N), .DW(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_data   (req_data),
        .gnt        (gnt),
        .fifo_wr_en (fifo_wr_en),
        .fifo_din   (fifo_din),
        .fifo_full  (fifo_full),
        .fifo_rd_en (fifo_rd_en),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_ready    (m_ready)
    );

    always #5 clk = ~clk;

    // Behavioural 16x8 FIFO with registered read data
    logic [DW-1:0] fmem [16];
    logic [3:0]    wp = '0, rp = '0;
    logic [4:0]    cnt = '0;
    logic [DW-1:0] fdout = '0;
    assign fifo_full  = (cnt == 5'd16);
    assign fifo_empty = (cnt == 5'd0);
    assign fifo_dout  = fdout;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp    <= '0;
            rp    <= '0;
            cnt   <= '0;
            fdout <= '0;
        end else begin
            if (fifo_wr_en && !fifo_full) begin
                fmem[wp] <= fifo_din;
                wp       <= wp + 4'd1;
            end
            if (fifo_rd_en && !fifo_empty) begin
                fdout <= fmem[rp];
                rp    <= rp + 4'd1;
            end
            cnt <= cnt + 5'(fifo_wr_en && !fifo_full) - 5'(fifo_rd_en && !fifo_empty);
        end
    end

    int            checks = 0;
    int            failures = 0;
    logic [DW-1:0] sb [$];
    int            model_ptr = 0;
    int            last_win = -1;
    logic [N-1:0]  obs_gnt = '0;
    logic          last_pop = 1'b0;
    bit            drop_on_grant = 1'b0;
    bit            inc_on_grant = 1'b0;
    bit            rand_mode = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Reference arbiter: rotate from the pointer, first requester wins unless full.
    task automatic model_arb();
        int            win;
        logic [N-1:0]  e_gnt;
        logic [DW-1:0] e_din;
        win   = -1;
        e_gnt = '0;
        e_din = '0;
        if (!fifo_full) begin
            for (int off = 0; off < N; off++) begin
                int c;
                c = (model_ptr + off) % N;
                if (win < 0 && req[c]) win = c;
            end
        end
        if (win >= 0) begin
            e_gnt[win] = 1'b1;
            e_din      = req_data[win*DW +: DW];
        end
        check("gnt", 32'(gnt), 32'(e_gnt));
        check("wr_en", 32'(fifo_wr_en), 32'(win >= 0));
        check("fifo_din", 32'(fifo_din), 32'(e_din));
        if (win >= 0) begin
            sb.push_back(e_din);
            model_ptr = (win + 1) % N;
        end
        obs_gnt  = gnt;
        last_win = win;
        last_pop = m_valid & m_ready;
    endtask

    task automatic step();
        @(negedge clk);
        model_arb();
        @(posedge clk);
        #1;
        if (last_win >= 0 && drop_on_grant) req[last_win] = 1'b0;
        if (last_win == 0 && inc_on_grant) req_data[DW-1:0] = req_data[DW-1:0] + 8'd1;
        if (rand_mode) begin
            for (int i = 0; i < N; i++) begin
                if (!req[i] && $urandom_range(0, 3) == 0) begin
                    req[i] = 1'b1;
                    req_data[i*DW +: DW] = DW'($urandom);
                end
            end
            m_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        req = '0;
        m_ready = 1'b1;
        while ((sb.size() != 0 || m_valid) && n < 60) begin
            step();
            n++;
        end
        check(name, 32'(sb.size()), 32'd0);
    endtask

    // Monitor: every transfer must match the oldest expected word
    initial begin
        bit            hold_prev;
        logic [DW-1:0] prev_data;
        logic [DW-1:0] exp;
        hold_prev = 1'b0;
        prev_data = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                hold_prev = 1'b0;
            end else begin
                if (hold_prev) begin
                    check("hold_valid", 32'(m_valid), 32'd1);
                    check("hold_data", 32'(m_data), 32'(prev_data));
                end
                if (m_valid && m_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL pop_unexpected actual=0x%0h required=no_word", m_data);
                    end else begin
                        exp = sb.pop_front();
                        check("m_data", 32'(m_data), 32'(exp));
                    end
                end
                check("wr_while_full", 32'(fifo_wr_en & fifo_full), 32'd0);
                check("rd_while_empty", 32'(fifo_rd_en & fifo_empty), 32'd0);
                hold_prev = m_valid & ~m_ready;
                prev_data = m_data;
            end
        end
    end

    initial begin
        int n, ch2_grants, first, last, total, expect_words;
        bit pops [40];

        // Reset state with all channels requesting
        #2 rst = 1'b0;
        req      = 4'b1111;
        req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        @(negedge clk);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_wr_en", 32'(fifo_wr_en), 32'd0);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        check("rst_m_data", 32'(m_data), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;

        // Round robin with all requests held
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            logic [N-1:0] e;
            step();
            e = N'(1) << (i % N);
            check("rr_gnt", 32'(obs_gnt), 32'(e));
        end
        drain("rr_drain");

        // Fill the FIFO plus the 2-entry buffer from channel 0 with consumer stalled
        m_ready = 1'b0;
        req_data = '0;
        req_data[DW-1:0] = 8'h11;
        req = 4'b0001;
        drop_on_grant = 1'b0;
        inc_on_grant = 1'b1;
        n = 0;
        while (!fifo_full && n < 60) begin
            step();
            n++;
        end
        check("fill_full", 32'(fifo_full), 32'd1);
        inc_on_grant = 1'b0;
        drop_on_grant = 1'b1;
        req = 4'b0100;
        req_data[2*DW +: DW] = 8'hC2;
        ch2_grants = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (last_win == 2) ch2_grants++;
        end
        check("full_no_grant", 32'(ch2_grants), 32'd0);
        check("stall_valid", 32'(m_valid), 32'd1);
        check("stall_data", 32'(m_data), 32'h11);
        check("stall_rd_en", 32'(fifo_rd_en), 32'd0);
        check("stall_fifo_cnt", 32'(cnt), 32'd16);

        // One pop frees a slot; channel 2 must be granted exactly once
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (last_win == 2) ch2_grants++;
        end
        check("ch2_once", 32'(ch2_grants), 32'd1);

        // Streaming: remaining words leave on consecutive cycles
        expect_words = sb.size();
        req = '0;
        m_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            pops[i] = last_pop;
        end
        first = -1;
        last = -1;
        total = 0;
        for (int i = 0; i < 40; i++) begin
            if (pops[i]) begin
                if (first < 0) first = i;
                last = i;
                total++;
            end
        end
        check("stream_count", 32'(total), 32'(expect_words));
        check("stream_gapless", 32'(last - first + 1), 32'(total));
        check("stream_empty", 32'(sb.size()), 32'd0);

        // Reset in mid-operation with output held
        m_ready = 1'b0;
        req = 4'b1111;
        req_data = {8'h53, 8'h52, 8'h51, 8'h50};
        drop_on_grant = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("pre_rst_valid", 32'(m_valid), 32'd1);
        rst = 1'b0;
        #1;
        check("async_m_valid", 32'(m_valid), 32'd0);
        check("async_gnt", 32'(gnt), 32'd0);
        check("async_rd_en", 32'(fifo_rd_en), 32'd0);
        check("async_wr_en", 32'(fifo_wr_en), 32'd0);
        sb.delete();
        model_ptr = 0;
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        drop_on_grant = 1'b1;
        step();
        check("post_rst_gnt", 32'(obs_gnt), 32'b0001);

        // Random traffic against the reference model
        rand_mode = 1'b1;
        repeat (1000) step();
        rand_mode = 1'b0;
        drain("final_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
